// File: rtl/jt900h_fetchq.sv
// jt900h_fetchq: byte prefetch queue plus RAM bus arbiter for the JT900H core.
// A single bus transfer is in flight at a time. Operand reads (DATA) win over
// prefetch (FETCH) at transaction boundaries. Jumps flush the queue, and a
// fetch still in flight when a jump arrives is marked stale so that its data
// is dropped when it lands.
module jt900h_fetchq #(
  parameter int          DW    = 16,
  parameter int          QB    = 8,
  parameter logic [23:0] START = 24'h000000,
  parameter int          CW    = $clog2(QB+1)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          jmp,
  input  logic [23:0]   jmp_addr,
  output logic [31:0]   op,
  output logic [CW-1:0] op_cnt,
  input  logic [2:0]    op_used,
  output logic [23:0]   pc,
  input  logic          data_rq,
  input  logic [23:0]   data_addr,
  output logic [DW-1:0] data_dout,
  output logic          data_ok,
  output logic [23:0]   ram_addr,
  output logic          ram_cs,
  input  logic [DW-1:0] ram_din,
  input  logic          ram_ok
);
  localparam int BW = DW/8;
  localparam int SW = $clog2(BW);
  localparam int QW = $clog2(QB);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    q_reg  [QB];
  logic [7:0]    q_next [QB];
  logic [7:0]    din_b  [BW];
  logic [CW-1:0] op_cnt_reg, op_cnt_next, keep_n, push_n;
  logic [23:0]   pc_reg, pc_next, fa_reg, fa_next;
  logic [23:0]   ram_addr_reg, ram_addr_next;
  logic [SW-1:0] skip_reg, skip_next;
  logic          stale_reg, stale_next;
  logic          ram_cs_reg, ram_cs_next;
  logic          data_ok_reg, data_ok_next;
  logic [DW-1:0] data_dout_reg, data_dout_next;
  logic          xfer_done, fetch_done, data_done, push_en, data_req;
  logic          unused_addr_bits;

  genvar gi;

  generate
    for (gi = 0; gi < BW; gi++) begin : g_din
      assign din_b[gi] = ram_din[8*gi +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_op
      assign op[8*gi +: 8] = q_reg[gi];
    end
  endgenerate

  // The operand address is always word aligned on the bus
  assign unused_addr_bits = ^data_addr[SW-1:0];

  assign op_cnt    = op_cnt_reg;
  assign pc        = pc_reg;
  assign data_dout = data_dout_reg;
  assign data_ok   = data_ok_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_cs    = ram_cs_reg;

  assign xfer_done  = ram_cs_reg & ram_ok;
  assign fetch_done = xfer_done & (state_reg == FETCH);
  assign data_done  = xfer_done & (state_reg == DATA);
  // Stale data and data landing together with a jump never enter the queue
  assign push_en    = fetch_done & ~stale_reg & ~jmp;
  // While data_ok is up the decoder has not yet dropped its request
  assign data_req   = data_rq & ~data_ok_reg & ~data_done;

  // Queue occupancy, PC, fetch pointer and stale tracking for the next edge
  always_comb begin
    keep_n      = jmp ? '0 : op_cnt_reg - CW'(op_used);
    push_n      = push_en ? CW'(BW) - CW'(skip_reg) : '0;
    op_cnt_next = keep_n + push_n;
    pc_next     = jmp ? jmp_addr : pc_reg + 24'(op_used);
    fa_next     = fa_reg;
    skip_next   = skip_reg;
    stale_next  = stale_reg;
    if (fetch_done) begin
      stale_next = 1'b0;
      if (!stale_reg) begin
        fa_next   = fa_reg + 24'(BW);
        skip_next = '0;
      end
    end
    if (jmp) begin
      fa_next    = {jmp_addr[23:SW], {SW{1'b0}}};
      skip_next  = jmp_addr[SW-1:0];
      stale_next = (state_reg == FETCH) && !fetch_done;
    end
  end

  // Queue contents: shift out consumed bytes, append fetched bytes after the survivors
  always_comb begin : queue_comb
    int src;
    int k;
    src    = 0;
    k      = 0;
    q_next = q_reg;
    for (int i = 0; i < QB; i++) begin
      src = i + int'(op_used);
      k   = i - int'(keep_n) + int'(skip_reg);
      if (src < QB)
        q_next[i] = q_reg[QW'(src)];
      if (push_en && i >= int'(keep_n) && k < BW)
        q_next[i] = din_b[SW'(k)];
    end
  end

  // Bus FSM: hold a request until ram_ok, then re-arbitrate on the same edge
  always_comb begin
    state_next     = state_reg;
    ram_cs_next    = ram_cs_reg;
    ram_addr_next  = ram_addr_reg;
    data_ok_next   = 1'b0;
    data_dout_next = data_dout_reg;
    if (data_done) begin
      data_ok_next   = 1'b1;
      data_dout_next = ram_din;
    end
    if (state_reg == IDLE || xfer_done) begin
      state_next  = IDLE;
      ram_cs_next = 1'b0;
      if (data_req) begin
        state_next    = DATA;
        ram_cs_next   = 1'b1;
        ram_addr_next = {data_addr[23:SW], {SW{1'b0}}};
      end else if (int'(op_cnt_next) <= QB - BW) begin
        state_next    = FETCH;
        ram_cs_next   = 1'b1;
        ram_addr_next = {fa_next[23:SW], {SW{1'b0}}};
      end
    end
  end

  // All state registers; nothing moves while cen is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      op_cnt_reg    <= '0;
      pc_reg        <= START;
      fa_reg        <= START;
      skip_reg      <= START[SW-1:0];
      stale_reg     <= 1'b0;
      ram_cs_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      data_ok_reg   <= 1'b0;
      data_dout_reg <= '0;
      for (int i = 0; i < QB; i++) q_reg[i] <= '0;
    end else if (cen) begin
      state_reg     <= state_next;
      op_cnt_reg    <= op_cnt_next;
      pc_reg        <= pc_next;
      fa_reg        <= fa_next;
      skip_reg      <= skip_next;
      stale_reg     <= stale_next;
      ram_cs_reg    <= ram_cs_next;
      ram_addr_reg  <= ram_addr_next;
      data_ok_reg   <= data_ok_next;
      data_dout_reg <= data_dout_next;
      q_reg         <= q_next;
    end
  end

endmodule

// File: tb/tb_jt900h_fetchq.sv
// Testbench for jt900h_fetchq: a 16-bit instance (START=0x100) runs the
// directed scenarios and then random traffic against a byte-stream model; a
// 32-bit instance runs the unaligned jump scenario. Memory byte A holds A[7:0].
module tb_jt900h_fetchq;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit bus instance
  logic        rst, cen, jmp, data_rq, data_ok, ram_cs, ram_ok;
  logic [23:0] jmp_addr, pc, data_addr, ram_addr;
  logic [31:0] op;
  logic [3:0]  op_cnt;
  logic [2:0]  op_used;
  logic [15:0] data_dout, ram_din;

  // 32-bit bus instance
  logic        rst_w, cen_w, jmp_w, data_rq_w, data_ok_w, ram_cs_w, ram_ok_w;
  logic [23:0] jmp_addr_w, pc_w, data_addr_w, ram_addr_w;
  logic [31:0] op_w, data_dout_w, ram_din_w;
  logic [4:0]  op_cnt_w;
  logic [2:0]  op_used_w;

  int total = 0;
  int bad   = 0;

  // Reference model of the 16-bit instance: a stream of bytes from m_pc onward
  int          m_cnt;
  logic [23:0] m_pc, m_next;
  logic        m_stale, m_dok;
  logic [15:0] m_dout;

  function automatic logic [15:0] mem16(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd1, b};
  endfunction

  function automatic logic [31:0] mem32(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  assign ram_din   = mem16(ram_addr);
  assign ram_din_w = mem32(ram_addr_w);

  jt900h_fetchq #(.DW(16), .QB(8), .START(24'h000100)) u_dut16 (
    .clk(clk), .rst(rst), .cen(cen), .jmp(jmp), .jmp_addr(jmp_addr),
    .op(op), .op_cnt(op_cnt), .op_used(op_used), .pc(pc),
    .data_rq(data_rq), .data_addr(data_addr), .data_dout(data_dout), .data_ok(data_ok),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_din(ram_din), .ram_ok(ram_ok)
  );

  jt900h_fetchq #(.DW(32), .QB(16), .START(24'h000000)) u_dut32 (
    .clk(clk), .rst(rst_w), .cen(cen_w), .jmp(jmp_w), .jmp_addr(jmp_addr_w),
    .op(op_w), .op_cnt(op_cnt_w), .op_used(op_used_w), .pc(pc_w),
    .data_rq(data_rq_w), .data_addr(data_addr_w), .data_dout(data_dout_w), .data_ok(data_ok_w),
    .ram_addr(ram_addr_w), .ram_cs(ram_cs_w), .ram_din(ram_din_w), .ram_ok(ram_ok_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_pc    = 24'h000100;
    m_next  = 24'h000100;
    m_stale = 1'b0;
    m_dok   = 1'b0;
    m_dout  = '0;
  endtask

  // One clock of the 16-bit instance: predict from the bus as the memory sees
  // it before the edge, then compare after the edge.
  task automatic step();
    logic        done, is_data, hold;
    logic [23:0] a;
    int          pushed;
    logic [31:0] eop, emask;
    a       = ram_addr;
    done    = cen && ram_cs && ram_ok;
    is_data = data_rq && (ram_addr == {data_addr[23:1], 1'b0});
    hold    = ram_cs && !done;
    pushed  = 0;
    if (cen) begin
      m_dok = 1'b0;
      if (done && is_data) begin
        m_dok  = 1'b1;
        m_dout = mem16(a);
      end
      if (done && !is_data) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          chk("fetch_addr", a, {m_next[23:1], 1'b0});
          pushed = int'(a) + 2 - int'(m_next);
        end
      end
      if (jmp) begin
        if (ram_cs && !is_data && !done) m_stale = 1'b1;
        m_cnt  = 0;
        m_pc   = jmp_addr;
        m_next = jmp_addr;
      end else begin
        m_cnt  = m_cnt - int'(op_used) + pushed;
        m_pc   = m_pc + 24'(op_used);
        m_next = m_next + 24'(pushed);
      end
    end
    @(posedge clk);
    #1;
    chk("op_cnt", op_cnt, m_cnt);
    chk("pc", pc, m_pc);
    chk("data_ok", data_ok, m_dok);
    if (m_dok) chk("data_dout", data_dout, m_dout);
    if (hold) begin
      chk("cs_held", ram_cs, 1'b1);
      chk("addr_held", ram_addr, a);
    end
    eop   = '0;
    emask = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < m_cnt) begin
        eop[8*i +: 8]   = 8'(m_pc + 24'(i));
        emask[8*i +: 8] = 8'hFF;
      end
    end
    chk("op_bytes", op & emask, eop);
  endtask

  initial begin
    int hi;
    rst = 1'b0; cen = 1'b1; jmp = 1'b0; jmp_addr = '0; op_used = '0;
    data_rq = 1'b0; data_addr = '0; ram_ok = 1'b1;
    rst_w = 1'b0; cen_w = 1'b1; jmp_w = 1'b0; jmp_addr_w = '0; op_used_w = '0;
    data_rq_w = 1'b0; data_addr_w = '0; ram_ok_w = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_cs", ram_cs, 1'b0);
    chk("rst_addr", ram_addr, 24'h0);
    chk("rst_op", op, 32'h0);
    chk("rst_cnt", op_cnt, 4'd0);
    chk("rst_pc", pc, 24'h000100);
    chk("rst_dok", data_ok, 1'b0);
    chk("rst_dout", data_dout, 16'h0);

    // 1: fill from START with ram_ok tied high
    rst = 1'b1;
    step();
    chk("t1_cs", ram_cs, 1'b1);
    chk("t1_addr0", ram_addr, 24'h000100);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t1_addr", ram_addr, 24'h000100 + 24'(2*i));
    end
    step();
    chk("t1_cnt", op_cnt, 4'd8);
    chk("t1_op", op, 32'h03020100);
    chk("t1_pc", pc, 24'h000100);
    chk("t1_idle_full", ram_cs, 1'b0);

    // 2: pop 3 bytes, one more fetch refills 2
    op_used = 3'd3;
    step();
    op_used = 3'd0;
    chk("t2_pc", pc, 24'h000103);
    chk("t2_op", op, 32'h06050403);
    chk("t2_cnt", op_cnt, 4'd5);
    chk("t2_addr", ram_addr, 24'h000108);
    step();
    chk("t2_cnt2", op_cnt, 4'd7);
    chk("t2_cs", ram_cs, 1'b0);

    // 3: jump during a stalled fetch; landing data dropped
    ram_ok = 1'b0;
    op_used = 3'd2;
    step();
    op_used = 3'd0;
    chk("t3_addr", ram_addr, 24'h00010A);
    step();
    jmp = 1'b1; jmp_addr = 24'h000201;
    step();
    jmp = 1'b0;
    chk("t3_cnt_jmp", op_cnt, 4'd0);
    chk("t3_addr_held", ram_addr, 24'h00010A);
    step();
    ram_ok = 1'b1;
    step();
    chk("t3_cnt_stale", op_cnt, 4'd0);
    chk("t3_addr_new", ram_addr, 24'h000200);
    step();
    chk("t3_cnt", op_cnt, 4'd1);
    chk("t3_op0", op[7:0], 8'h01);
    chk("t3_pc", pc, 24'h000201);

    // 4: operand read behind a pending fetch
    ram_ok = 1'b0;
    data_rq = 1'b1; data_addr = 24'h001235;
    step();
    chk("t4_fetch_first", ram_addr, 24'h000202);
    ram_ok = 1'b1;
    step();
    chk("t4_daddr", ram_addr, 24'h001234);
    chk("t4_cnt", op_cnt, 4'd3);
    step();
    chk("t4_dok", data_ok, 1'b1);
    chk("t4_dout", data_dout, 16'h3534);
    chk("t4_cnt2", op_cnt, 4'd3);
    data_rq = 1'b0;
    step();
    chk("t4_dok_pulse", data_ok, 1'b0);

    // 5: asynchronous reset in the middle of a fetch
    ram_ok = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("t5_cs", ram_cs, 1'b0);
    chk("t5_cnt", op_cnt, 4'd0);
    chk("t5_op", op, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; ram_ok = 1'b1;
    step();
    chk("t5_restart", ram_addr, 24'h000100);
    chk("t5_restart_cs", ram_cs, 1'b1);

    // Random traffic against the byte-stream model
    for (int n = 0; n < 3000; n++) begin
      cen      = ($urandom_range(0, 7) != 0);
      ram_ok   = ($urandom_range(0, 2) != 0);
      jmp      = ($urandom_range(0, 31) == 0);
      jmp_addr = 24'($urandom_range(0, 32'h000FFFFF));
      if (data_ok) data_rq = 1'b0;
      else if (!data_rq && $urandom_range(0, 15) == 0) begin
        data_rq   = 1'b1;
        data_addr = {1'b1, 23'($urandom)};
      end
      hi = (m_cnt < 4) ? m_cnt : 4;
      if (hi < 0) hi = 0;
      op_used = 3'($urandom_range(0, hi));
      step();
    end
    cen = 1'b1; jmp = 1'b0; op_used = '0;

    // 6: 32-bit bus, unaligned jump
    chk("t6_rst_cs", ram_cs_w, 1'b0);
    chk("t6_rst_cnt", op_cnt_w, 5'd0);
    chk("t6_rst_pc", pc_w, 24'h0);
    rst_w = 1'b1; jmp_w = 1'b1; jmp_addr_w = 24'h000403;
    @(posedge clk);
    #1;
    jmp_w = 1'b0;
    chk("t6_addr0", ram_addr_w, 24'h000400);
    chk("t6_pc", pc_w, 24'h000403);
    @(posedge clk);
    #1;
    chk("t6_cnt1", op_cnt_w, 5'd1);
    chk("t6_op0", op_w[7:0], 8'h03);
    chk("t6_addr1", ram_addr_w, 24'h000404);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t6_cnt", op_cnt_w, 5'(5 + 4*i));
    end
    chk("t6_op", op_w, 32'h06050403);
    chk("t6_full", ram_cs_w, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt900h_fetchq.md
# jt900h_fetchq

Parametrised instruction prefetch queue and bus arbiter for the JT900H core. It replaces the single-word fetch path between the RAM bus and the decoder with a byte queue of configurable depth, a configurable bus width and a wait-state handshake. It also arbitrates operand reads (`data_rq`) against prefetch, flushes on jumps, and gives the decoder up to 4 bytes of lookahead plus the PC of the first byte.

## Interface

**Parameters**

- `DW`, 16: RAM data bus width. Legal values: 16 or 32. `BW = DW/8` is the number of bytes per bus word.
- `QB`, 8: queue depth in bytes. Power of two, range 4..16, and `QB >= BW`.
- `START`, 24'h000000: first fetch address after reset.
- `CW`, `$clog2(QB+1)`: width of `op_cnt`.

**Ports**

- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-low (0 = reset).
- `cen`, in, 1: clock enable. All state updates happen only on rising `clk` edges with `cen=1`.
- `jmp`, in, 1: flush the queue and restart fetch at `jmp_addr`.
- `jmp_addr`, in, 24: new fetch byte address.
- `op`, out, 32: queue bytes 0..3, little-endian. `op[7:0]` is the byte at `pc`.
- `op_cnt`, out, CW: number of valid queue bytes, 0..QB.
- `op_used`, in, 3: bytes the decoder consumes this cycle, 0..4. It must be ≤ `op_cnt`.
- `pc`, out, 24: address of `op[7:0]`.
- `data_rq`, in, 1: operand read request. Level signal, held until `data_ok`.
- `data_addr`, in, 24: operand address. The low `log2(BW)` bits are ignored.
- `data_dout`, out, DW: operand word as received from the bus.
- `data_ok`, out, 1: one-cycle pulse when `data_dout` is valid.
- `ram_addr`, out, 24: byte address, always aligned to BW.
- `ram_cs`, out, 1: bus request.
- `ram_din`, in, DW: read data.
- `ram_ok`, in, 1: transfer complete. Sampled only while `ram_cs=1` and `cen=1`.

## Operation

**Reset values.** `ram_cs=0`, `ram_addr=0`, `op=0`, `op_cnt=0`, `pc=START`, `data_ok=0`, `data_dout=0`. The internal fetch address `fa` resets to `START`, the skip count to `START[log2(BW)-1:0]`, and the bus FSM to IDLE.

**Bus FSM states**

- IDLE:
  - If `data_rq` is high → DATA, with `ram_addr` = aligned `data_addr` and `ram_cs=1`.
  - Else if `QB - op_cnt_next >= BW` → FETCH, with `ram_addr` = aligned `fa` and `ram_cs=1`.
- FETCH / DATA: hold `ram_cs` and `ram_addr` stable until `ram_ok=1`.
  - On the `ram_ok` edge, go straight back through IDLE arbitration in the same edge, so back-to-back transfers have no idle cycle.
  - DATA completing: latch `ram_din` into `data_dout` and pulse `data_ok`.
  - FETCH completing: push bytes `skip..BW-1` of `ram_din` into the queue, add `BW` to `fa`, set `skip=0`.
- Arbitration happens only at transaction boundaries. A request is never aborted; `ram_cs` drops only in IDLE.
- DATA has priority over FETCH. The queue is never modified by a DATA transaction.

**Queue**

- Each cycle: `op_cnt_next = op_cnt - op_used + pushed`. Pop and push may happen in the same cycle. `pc` advances by `op_used`.
- `op` bytes at index ≥ `op_cnt` are don't-care.
- Full: no FETCH is issued when free space < `BW`. Because at most one transfer is in flight, a FETCH always has room when it lands.
- Empty: `op_cnt=0`. The decoder must present `op_used=0`.

**Jump**

- On `jmp` (with `cen`): `op_cnt←0`, `pc←jmp_addr`, `fa←jmp_addr` aligned down, `skip←jmp_addr[log2(BW)-1:0]`.
- `jmp` wins over `op_used` and over a FETCH landing in the same cycle; that data is discarded.
- A FETCH in flight when `jmp` arrives completes on the bus, but its data is discarded. Track this with a `stale` flag.
- A DATA transaction in flight when `jmp` arrives is unaffected.

**Reset mid-transfer.** All outputs go to their reset values immediately (asynchronous). Fetch restarts at `START` after release.

## Timing

- First `ram_cs=1` appears on the first `cen` edge after `rst` rises.
- With `ram_ok` tied high: fetch bytes are visible in `op`/`op_cnt` on the edge after the `ram_ok` cycle. Fill rate is `BW` bytes per `cen` cycle.
- With a DATA request and the bus idle: `ram_cs` rises on the next edge, and `data_ok` rises on the edge after the `ram_ok` cycle (minimum 2 cycles of latency).
- With `cen=0`: the whole block freezes, and `ram_ok` is ignored.

## Test plan

1. Config `DW=16`, `QB=8`, `START=0x000100`, `ram_ok=1`; the memory model returns byte A = A[7:0]. Release reset → four fetches at 0x100, 0x102, 0x104, 0x106. Then `op_cnt=8`, `op=0x03020100`, `pc=0x100`, and `ram_cs=0` with the queue full.
2. From the full state, `op_used=3` for one cycle → `pc=0x103`, `op=0x06050403`, `op_cnt=5`. FETCH 0x108 issues next cycle; after it lands, `op_cnt=7`.
3. Hold `ram_ok=0` for 3 cycles during a FETCH and pulse `jmp` with `jmp_addr=0x000201` → `ram_addr` stays stable until `ram_ok`, and the landing data is dropped. Next FETCH is at 0x200 and pushes only byte 0x01: `op_cnt=1`, `op[7:0]=0x01`, `pc=0x201`.
4. Raise `data_rq` with `data_addr=0x001235` while a FETCH is pending → the FETCH completes first, then `ram_addr=0x001234`. Result: `data_dout=0x3534`, a single-cycle `data_ok`, and `op_cnt` unchanged by the data access.
5. Drop `rst` mid-FETCH with `ram_ok=0` → `ram_cs`, `op_cnt` and `op` go to 0 immediately. After release, the first `ram_addr` is `START`.
6. Config `DW=32`, `QB=16`, and jump to 0x000403 → first FETCH at 0x400 pushes 1 byte (`op_cnt=1`, `op[7:0]=0x03`). Each later `ram_ok` adds 4 bytes.
